// File: rtl/rv32i_types.sv
// Shared RV32I types for the front end: opcode encodings, fetch FSM states,
// the canonical NOP word and a word-alignment helper.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;  // addi x0, x0, 0

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;

    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    modport master (
        output imem_address,
        output imem_read,
        input  imem_rdata,
        input  imem_resp
    );

    modport slave (
        input  imem_address,
        input  imem_read,
        output imem_rdata,
        output imem_resp
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, or is flushed to a
// NOP bubble; otherwise holds its contents.
module if_id_reg
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            instr <= RV32I_NOP;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= RV32I_NOP;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_in;
            instr <= instr_in;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: single-outstanding-request fetch FSM, PC,
// one-entry stall buffer and IF/ID register. Optional performance counters
// are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                id_valid,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_instr,
    output rv32i_opcode         id_opcode,
    output logic [2:0]          id_funct3,
    output logic [6:0]          id_funct7,
    output logic [4:0]          id_rs1,
    output logic [4:0]          id_rs2,
    output logic [4:0]          id_rd
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         bubble_count
`endif
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  hold_pc, hold_pc_n;
    logic [31:0]  hold_instr, hold_instr_n;
    logic [31:0]  discard_addr, discard_addr_n;

    logic         id_load;
    logic         id_flush;
    logic [31:0]  id_load_pc;
    logic [31:0]  id_load_instr;

    // NOTE: the stall buffer is reset explicitly so a reset mid-stall can
    // never leak a stale instruction into IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            hold_pc      <= 32'h0;
            hold_instr   <= RV32I_NOP;
            discard_addr <= 32'h0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            hold_pc      <= hold_pc_n;
            hold_instr   <= hold_instr_n;
            discard_addr <= discard_addr_n;
        end
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        hold_pc_n      = hold_pc;
        hold_instr_n   = hold_instr;
        discard_addr_n = discard_addr;
        id_load        = 1'b0;
        id_flush       = 1'b0;
        id_load_pc     = pc;
        id_load_instr  = imem.imem_rdata;

        unique case (state)
            FETCH: begin
                if (redirect) begin
                    pc_n           = word_align(redirect_pc);
                    hold_pc_n      = 32'h0;
                    hold_instr_n   = RV32I_NOP;
                    id_flush       = 1'b1;
                    discard_addr_n = pc;
                    // A response arriving with the redirect is dropped here;
                    // otherwise it is still in flight and must be swallowed.
                    state_n        = imem.imem_resp ? FETCH : DISCARD;
                end else if (imem.imem_resp) begin
                    pc_n = pc + 32'd4;
                    if (stall) begin
                        hold_pc_n    = pc;
                        hold_instr_n = imem.imem_rdata;
                        state_n      = HOLD;
                    end else begin
                        id_load = 1'b1;
                    end
                end else if (!stall) begin
                    id_flush = 1'b1;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_n         = word_align(redirect_pc);
                    hold_pc_n    = 32'h0;
                    hold_instr_n = RV32I_NOP;
                    id_flush     = 1'b1;
                    state_n      = FETCH;
                end else if (!stall) begin
                    id_load       = 1'b1;
                    id_load_pc    = hold_pc;
                    id_load_instr = hold_instr;
                    hold_pc_n     = 32'h0;
                    hold_instr_n  = RV32I_NOP;
                    state_n       = FETCH;
                end
            end

            DISCARD: begin
                if (redirect) begin
                    pc_n     = word_align(redirect_pc);
                    id_flush = 1'b1;
                end else if (!stall) begin
                    id_flush = 1'b1;
                end
                if (imem.imem_resp) begin
                    state_n = FETCH;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // While discarding, the abandoned request stays on the bus unchanged
    // until its response arrives.
    assign imem.imem_read    = !rst && (state != HOLD);
    assign imem.imem_address = (state == DISCARD) ? discard_addr : pc;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (id_load),
        .flush    (id_flush),
        .pc_in    (id_load_pc),
        .instr_in (id_load_instr),
        .valid    (id_valid),
        .pc       (id_pc),
        .instr    (id_instr)
    );

    assign id_opcode = rv32i_opcode'(id_instr[6:0]);
    assign id_rd     = id_instr[11:7];
    assign id_funct3 = id_instr[14:12];
    assign id_rs1    = id_instr[19:15];
    assign id_rs2    = id_instr[24:20];
    assign id_funct7 = id_instr[31:25];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count  <= 32'h0;
            bubble_count <= 32'h0;
        end else begin
            if (id_load) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (!id_valid) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the memory side is driven
// cycle by cycle with hand-computed expected values.
module tb_fetch_stage;

    import rv32i_types::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    rv32i_opcode id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int obs_bubbles = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h4000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_bus),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
        .id_opcode    (id_opcode),
        .id_funct3    (id_funct3),
        .id_funct7    (id_funct7),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock; bubble cycles are tallied from the pre-edge value.
    task automatic tick();
        if (!rst && !id_valid) obs_bubbles++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_resp(input logic resp, input logic [31:0] rdata);
        imem_bus.imem_resp  = resp;
        imem_bus.imem_rdata = rdata;
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        set_resp(1'b0, 32'h0);

        // Reset state
        tick();
        check("rst_read",   32'(imem_bus.imem_read), 32'h0);
        check("rst_valid",  32'(id_valid), 32'h0);
        check("rst_pc",     id_pc, 32'h0);
        check("rst_instr",  id_instr, 32'h0000_0013);
        rst = 1'b0;
        #1;
        check("first_read", 32'(imem_bus.imem_read), 32'h1);
        check("first_addr", imem_bus.imem_address, 32'h4000_0000);

        // Basic fetch, response one cycle after the request
        tick();
        check("held_read", 32'(imem_bus.imem_read), 32'h1);
        check("held_addr", imem_bus.imem_address, 32'h4000_0000);
        set_resp(1'b1, 32'h0050_0093);
        tick();
        set_resp(1'b0, 32'h0);
        check("f0_valid",  32'(id_valid), 32'h1);
        check("f0_pc",     id_pc, 32'h4000_0000);
        check("f0_instr",  id_instr, 32'h0050_0093);
        check("f0_opcode", 32'(id_opcode), 32'h13);
        check("f0_rd",     32'(id_rd), 32'h1);
        check("f0_rs1",    32'(id_rs1), 32'h0);
        check("f0_rs2",    32'(id_rs2), 32'h5);
        check("f0_funct3", 32'(id_funct3), 32'h0);
        check("f0_funct7", 32'(id_funct7), 32'h0);
        check("f0_next",   imem_bus.imem_address, 32'h4000_0004);
        check("f0_read",   32'(imem_bus.imem_read), 32'h1);

        // Stall at a response: buffered, IF/ID frozen, released once
        stall = 1'b1;
        tick();
        check("st_req_valid", 32'(id_valid), 32'h1);
        check("st_req_pc",    id_pc, 32'h4000_0000);
        set_resp(1'b1, 32'h0020_8133);
        tick();
        set_resp(1'b0, 32'h0);
        check("hold0_read",  32'(imem_bus.imem_read), 32'h0);
        check("hold0_instr", id_instr, 32'h0050_0093);
        check("hold0_pc",    id_pc, 32'h4000_0000);
        check("hold0_valid", 32'(id_valid), 32'h1);
        tick();
        check("hold1_read",  32'(imem_bus.imem_read), 32'h0);
        check("hold1_instr", id_instr, 32'h0050_0093);
        tick();
        check("hold2_read",  32'(imem_bus.imem_read), 32'h0);
        check("hold2_pc",    id_pc, 32'h4000_0000);
        stall = 1'b0;
        tick();
        check("rel_valid",  32'(id_valid), 32'h1);
        check("rel_pc",     id_pc, 32'h4000_0004);
        check("rel_instr",  id_instr, 32'h0020_8133);
        check("rel_opcode", 32'(id_opcode), 32'h33);
        check("rel_rs1",    32'(id_rs1), 32'h1);
        check("rel_rs2",    32'(id_rs2), 32'h2);
        check("rel_rd",     32'(id_rd), 32'h2);
        check("rel_read",   32'(imem_bus.imem_read), 32'h1);
        check("rel_addr",   imem_bus.imem_address, 32'h4000_0008);
        tick();
        check("no_dup_valid", 32'(id_valid), 32'h0);

        // Redirect while a request is pending: late response dropped
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0103;
        tick();
        redirect = 1'b0;
        check("rdp_valid", 32'(id_valid), 32'h0);
        check("rdp_instr", id_instr, 32'h0000_0013);
        check("rdp_read",  32'(imem_bus.imem_read), 32'h1);
        check("rdp_addr",  imem_bus.imem_address, 32'h4000_0008);
        set_resp(1'b1, 32'hDEAD_BEEF);
        tick();
        set_resp(1'b0, 32'h0);
        check("drop_valid", 32'(id_valid), 32'h0);
        check("drop_addr",  imem_bus.imem_address, 32'h4000_0100);
        check("drop_read",  32'(imem_bus.imem_read), 32'h1);
        tick();
        set_resp(1'b1, 32'h0030_8193);
        tick();
        set_resp(1'b0, 32'h0);
        check("tgt_valid", 32'(id_valid), 32'h1);
        check("tgt_pc",    id_pc, 32'h4000_0100);
        check("tgt_instr", id_instr, 32'h0030_8193);
        check("tgt_next",  imem_bus.imem_address, 32'h4000_0104);

        // Redirect coincident with a response and stall
        stall = 1'b1;
        tick();
        set_resp(1'b1, 32'h1111_1111);
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0200;
        tick();
        set_resp(1'b0, 32'h0);
        redirect = 1'b0;
        stall    = 1'b0;
        check("rc_valid", 32'(id_valid), 32'h0);
        check("rc_instr", id_instr, 32'h0000_0013);
        check("rc_addr",  imem_bus.imem_address, 32'h4000_0200);
        check("rc_read",  32'(imem_bus.imem_read), 32'h1);
        tick();
        set_resp(1'b1, 32'h0040_0213);
        tick();
        set_resp(1'b0, 32'h0);
        check("rc_tgt_pc",    id_pc, 32'h4000_0200);
        check("rc_tgt_instr", id_instr, 32'h0040_0213);

        // Redirect while holding a buffered response
        stall = 1'b1;
        tick();
        set_resp(1'b1, 32'h2222_2222);
        tick();
        set_resp(1'b0, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0300;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("rh_valid", 32'(id_valid), 32'h0);
        check("rh_read",  32'(imem_bus.imem_read), 32'h1);
        check("rh_addr",  imem_bus.imem_address, 32'h4000_0300);
        tick();
        set_resp(1'b1, 32'h0050_0293);
        tick();
        set_resp(1'b0, 32'h0);
        check("rh_tgt_pc",    id_pc, 32'h4000_0300);
        check("rh_tgt_instr", id_instr, 32'h0050_0293);

        // Double redirect while discarding, then PC wrap at 0xFFFFFFFC
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0500;
        tick();
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect = 1'b0;
        check("dd_read",  32'(imem_bus.imem_read), 32'h1);
        check("dd_addr",  imem_bus.imem_address, 32'h4000_0304);
        check("dd_valid", 32'(id_valid), 32'h0);
        set_resp(1'b1, 32'h3333_3333);
        tick();
        set_resp(1'b0, 32'h0);
        check("wrap_addr",  imem_bus.imem_address, 32'hFFFF_FFFC);
        check("wrap_valid", 32'(id_valid), 32'h0);
        tick();
        set_resp(1'b1, 32'h0060_0313);
        tick();
        set_resp(1'b0, 32'h0);
        check("wrap_pc",    id_pc, 32'hFFFF_FFFC);
        check("wrap_instr", id_instr, 32'h0060_0313);
        check("wrap_next",  imem_bus.imem_address, 32'h0000_0000);

        // Reset in the middle of a request
        tick();
        rst = 1'b1;
        tick();
        check("mr_read",  32'(imem_bus.imem_read), 32'h0);
        check("mr_valid", 32'(id_valid), 32'h0);
        check("mr_pc",    id_pc, 32'h0);
        check("mr_instr", id_instr, 32'h0000_0013);
        rst = 1'b0;
        obs_bubbles = 0;
        #1;
        check("mr_addr",   imem_bus.imem_address, 32'h4000_0000);
        check("mr_read2",  32'(imem_bus.imem_read), 32'h1);
        check("mr_valid2", 32'(id_valid), 32'h0);

`ifdef FETCH_PERF_CNT_EN
        // Ten delivered fetches with one redirect in the middle
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                redirect    = 1'b1;
                redirect_pc = 32'h4000_0400;
                tick();
                redirect = 1'b0;
                set_resp(1'b1, 32'h4444_4444);
                tick();
                set_resp(1'b0, 32'h0);
            end
            tick();
            set_resp(1'b1, 32'h0000_0013 + 32'(i) * 32'h100);
            tick();
            set_resp(1'b0, 32'h0);
        end
        check("perf_fetch",  fetch_count, 32'd10);
        check("perf_bubble", bubble_count, 32'(obs_bubbles));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter: RESET_PC, 32'h4000_0000, PC loaded on reset.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: imem_address  output  32  fetch address, word-aligned.
REQ-006 Port: imem_read  output  1  fetch request, held until imem_resp.
REQ-007 Port: imem_rdata  input  32  instruction word, valid with imem_resp.
REQ-008 Port: imem_resp  input  1  one-cycle completion of the outstanding request.
REQ-009 Port: stall  input  1  downstream hazard; hold IF/ID contents.
REQ-010 Port: redirect  input  1  taken branch/jump from EX; flush and refetch.
REQ-011 Port: redirect_pc  input  32  target; bits [1:0] ignored (treated as 0).
REQ-012 Port: id_valid  output  1  IF/ID holds a real instruction.
REQ-013 Port: id_pc  output  32  PC of id_instr.
REQ-014 Port: id_instr  output  32  IF/ID instruction word.
REQ-015 Ports: id_opcode (rv32i_opcode, 7), id_funct3 (3), id_funct7 (7), id_rs1/id_rs2/id_rd (5 each); outputs; combinational slices of id_instr feeding the control ROM.

Function
REQ-016 States SHALL be FETCH (request outstanding), HOLD (response buffered, downstream stalled), DISCARD (outstanding response to be dropped).
REQ-017 FETCH: imem_read=1, imem_address=pc, both stable until imem_resp.
REQ-018 FETCH, imem_resp, !stall, !redirect: next cycle id_valid=1, id_instr=imem_rdata, id_pc=pc, pc=pc+4 (mod 2^32); new request issued same next cycle.
REQ-019 FETCH, imem_resp, stall, !redirect: response into hold register, pc=pc+4, go HOLD; imem_read=0 while in HOLD.
REQ-020 HOLD, !stall: hold register moves to IF/ID (id_valid=1) next cycle, go FETCH.
REQ-021 While stall=1 and no redirect, id_valid/id_pc/id_instr SHALL not change.
REQ-022 Redirect SHALL have priority over stall and imem_resp: next cycle id_valid=0, id_instr=32'h0000_0013, pc=redirect_pc, hold register cleared.
REQ-023 Redirect in FETCH without imem_resp: go DISCARD; next imem_resp dropped; then FETCH at redirect_pc.
REQ-024 Redirect coincident with imem_resp, or in HOLD: response/buffer dropped, go FETCH at redirect_pc next cycle.
REQ-025 Redirect in DISCARD: pc updated to newest redirect_pc; remain DISCARD until imem_resp.
REQ-026 Fetch-to-IF/ID latency SHALL be one cycle after imem_resp; at most one request outstanding.

Reset
REQ-027 On rst: pc=RESET_PC, state FETCH, id_valid=0, id_pc=0, id_instr=32'h0000_0013, hold register empty, imem_read=0 in the reset cycle.
REQ-028 First cycle after rst deasserts: imem_read=1, imem_address=RESET_PC; reset mid-transaction abandons the request (memory reset with the core).

Configuration
REQ-029 Macro FETCH_PERF_CNT_EN defined: outputs fetch_count (32, increments per instruction entering IF/ID) and bubble_count (32, increments each cycle id_valid=0 after reset), both reset to 0, wrapping at 2^32.
REQ-030 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-031 fetch_state_t enum and the RV32I NOP constant (32'h0000_0013) SHALL live in rv32i_types; rv32i_opcode reused from it.
REQ-032 One sub-module, if_id_reg (valid/pc/instr register with load and flush), SHALL be instantiated; FSM and PC stay in fetch_stage.

Verification
REQ-033 Reset, imem_resp 1 cycle after each request, rdata 0x00500093 -> address 0x40000000, id_pc 0x40000000 one cycle after resp, next address 0x40000004.
REQ-034 stall=1 for 3 cycles at a resp -> IF/ID unchanged, imem_read=0 in HOLD, buffered word appears first cycle after stall drops, no instruction lost or duplicated.
REQ-035 redirect=1, redirect_pc 0x40000103, while request pending -> id_valid=0, late response dropped, next address 0x40000100.
REQ-036 redirect coincident with imem_resp and stall=1 -> response dropped, id_valid=0, fetch at target next cycle.
REQ-037 pc 0xFFFFFFFC fetch -> next address 0x00000000; rst asserted mid-request -> address 0x40000000 after reset, id_valid=0.
REQ-038 With FETCH_PERF_CNT_EN, 10 fetches and 1 redirect -> fetch_count=10, bubble_count equals observed id_valid=0 cycles.
